// File: rtl/hydra_pkt_gen.sv
// hydra_pkt_gen: per-port hydra packet generator with length/dest modes, packet budget, gap and pause
module hydra_pkt_gen #(
  parameter int          PORT_NUM   = 16,
  parameter int          DATA_WIDTH = 16,
  parameter int          LEN_WIDTH  = 9,
  parameter int          MIN_LEN    = 32,
  parameter int          MAX_LEN    = 100,
  parameter int          GAP_CYC    = 2,
  parameter int          CNT_WIDTH  = 16,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [PORT_NUM-1:0]             enable,
  input  logic [PORT_NUM-1:0]             pause,
  input  logic [1:0]                      len_mode,
  input  logic [1:0]                      dest_mode,
  input  logic [LEN_WIDTH-1:0]            cfg_len,
  input  logic [2:0]                      cfg_prio,
  input  logic [3:0]                      cfg_dest,
  input  logic [CNT_WIDTH-1:0]            pkt_target,
  output logic [PORT_NUM-1:0]             wr_sop,
  output logic [PORT_NUM-1:0]             wr_eop,
  output logic [PORT_NUM-1:0]             wr_vld,
  output logic [PORT_NUM*DATA_WIDTH-1:0]  wr_data,
  output logic [PORT_NUM*CNT_WIDTH-1:0]   pkt_sent,
  output logic [PORT_NUM-1:0]             done
);
  typedef enum logic [2:0] {IDLE, SOP, HDR, DATA, EOP, GAP} state_t;
  localparam int GW = GAP_CYC > 1 ? $clog2(GAP_CYC) : 1;
  for (genvar i = 0; i < PORT_NUM; i++) begin : g_ch
    localparam logic [15:0] SX = SEED ^ 16'(i);
    localparam logic [15:0] SD = SX == 16'd0 ? 16'd1 : SX;
    state_t                 state;
    logic [15:0]            lfsr, lfsr_nxt;
    logic [LEN_WIDTH-1:0]   len, inc_len, cnt, raw, len_lfsr, len_sel;
    logic [3:0]             rr, dest_sel;
    logic [GW-1:0]          gcnt;
    logic                   sop, eop, vld, dn;
    logic [DATA_WIDTH-1:0]  data;
    logic [CNT_WIDTH-1:0]   sent, sent_nxt;
    always_comb begin
      lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      raw      = lfsr_nxt[LEN_WIDTH-1:0];
      len_lfsr = raw < LEN_WIDTH'(MIN_LEN) ? LEN_WIDTH'(MIN_LEN) :
                 raw > LEN_WIDTH'(MAX_LEN) ? LEN_WIDTH'(MAX_LEN) : raw;
      len_sel  = len_mode == 2'd1 ? inc_len :
                 len_mode == 2'd2 ? len_lfsr :
                 cfg_len == '0 ? LEN_WIDTH'(1) : cfg_len;
      dest_sel = dest_mode == 2'd1 ? rr :
                 dest_mode == 2'd2 ? 4'(32'(lfsr_nxt[3:0]) % PORT_NUM) : cfg_dest;
      sent_nxt = &sent ? sent : sent + 1'b1;
    end
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state   <= IDLE;
        lfsr    <= SD;
        inc_len <= LEN_WIDTH'(MIN_LEN);
        rr      <= 4'(i);
        len     <= '0;
        cnt     <= '0;
        gcnt    <= '0;
        sop     <= 1'b0;
        eop     <= 1'b0;
        vld     <= 1'b0;
        data    <= '0;
        sent    <= '0;
        dn      <= 1'b0;
      end else begin
        sop  <= 1'b0;
        eop  <= 1'b0;
        vld  <= 1'b0;
        data <= '0;
        case (state)
          IDLE: if (enable[i] && !pause[i] && !dn) begin
            state <= SOP;
            sop   <= 1'b1;
          end
          SOP: begin
            state <= HDR;
            vld   <= 1'b1;
            len   <= len_sel;
            cnt   <= '0;
            lfsr  <= lfsr_nxt;
            data  <= DATA_WIDTH'({len_sel, cfg_prio, dest_sel});
            if (len_mode == 2'd1)
              inc_len <= inc_len == LEN_WIDTH'(MAX_LEN) ? LEN_WIDTH'(MIN_LEN) : inc_len + 1'b1;
            if (dest_mode == 2'd1)
              rr <= rr == 4'(PORT_NUM - 1) ? 4'd0 : rr + 1'b1;
          end
          HDR: begin
            // data stays 0 here, which is payload word 0
            state <= DATA;
            vld   <= 1'b1;
            cnt   <= LEN_WIDTH'(1);
          end
          DATA: if (cnt == len) begin
            state <= EOP;
            eop   <= 1'b1;
            sent  <= sent_nxt;
            if (pkt_target != '0 && sent_nxt == pkt_target) dn <= 1'b1;
          end else begin
            vld  <= 1'b1;
            data <= DATA_WIDTH'(cnt);
            cnt  <= cnt + 1'b1;
          end
          EOP: begin
            state <= GAP_CYC == 0 ? IDLE : GAP;
            gcnt  <= '0;
          end
          GAP: begin
            if (gcnt == GW'(GAP_CYC - 1)) state <= IDLE;
            gcnt <= gcnt + 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
    assign wr_sop[i] = sop;
    assign wr_eop[i] = eop;
    assign wr_vld[i] = vld;
    assign done[i]   = dn;
    assign wr_data[i*DATA_WIDTH +: DATA_WIDTH] = data;
    assign pkt_sent[i*CNT_WIDTH +: CNT_WIDTH]  = sent;
  end
endmodule

// File: doc/hydra_pkt_gen.md
Name: hydra_pkt_gen

Overview:
Parametrised, synthesizable multi-channel packet generator that drives the hydra switch write interface (wr_sop/wr_eop/wr_vld/wr_data). One independent generator per ingress port. Each generator emits hydra-format packets with configurable length, priority and destination modes, a packet budget, an inter-packet gap and honouring of hydra pause. It replaces hand-written per-port stimulus loops and sits between a config source (bench or CSR) and hydra.

Parameters:
PORT_NUM, 16, number of channels (= hydra ports)
DATA_WIDTH, 16, wr_data word width per channel
LEN_WIDTH, 9, header length field width (header bits [15:7])
MIN_LEN, 32, lower clamp for generated payload length (words)
MAX_LEN, 100, upper clamp for generated payload length (words)
GAP_CYC, 2, idle cycles after each eop before the next packet may start
CNT_WIDTH, 16, per-channel sent-packet counter width
SEED, 16'hACE1, LFSR seed base; channel i seeded with SEED ^ i (a result of 0 is replaced by 1)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
enable  in  PORT_NUM  per-channel generator enable
pause  in  PORT_NUM  hydra backpressure, per channel
len_mode  in  2  0 fixed, 1 incrementing, 2 LFSR, 3 reserved (treated as 0)
dest_mode  in  2  0 fixed, 1 round-robin, 2 LFSR, 3 reserved (treated as 0)
cfg_len  in  LEN_WIDTH  fixed payload length
cfg_prio  in  3  header priority
cfg_dest  in  4  fixed destination port
pkt_target  in  CNT_WIDTH  packets per channel; 0 = unlimited
wr_sop  out  PORT_NUM  start-of-packet pulse
wr_eop  out  PORT_NUM  end-of-packet pulse
wr_vld  out  PORT_NUM  data valid
wr_data  out  PORT_NUM*DATA_WIDTH  channel i data at [i*DATA_WIDTH +: DATA_WIDTH]
pkt_sent  out  PORT_NUM*CNT_WIDTH  per-channel completed-packet count
done  out  PORT_NUM  channel reached pkt_target

Behaviour:
- Reset is synchronous: on a clk edge with rst_n=0, every channel goes to IDLE. All outputs go to 0: wr_sop, wr_eop, wr_vld, wr_data, pkt_sent, done. LFSRs reload their seed. Incrementing-length regs load MIN_LEN. Round-robin dest regs load the channel index. Reset mid-packet truncates the packet; no eop is emitted.
- All outputs are registered.
- Per-channel FSM: IDLE -> SOP -> HDR -> DATA -> EOP -> GAP -> IDLE. GAP is skipped when GAP_CYC=0.
- IDLE: go to SOP when enable[i] & ~pause[i] & ~done[i]. Outputs are 0.
- SOP: wr_sop[i]=1, wr_vld=0. Length, dest and prio are latched here; config changes after this point do not affect the packet in flight.
- HDR: wr_vld=1. Header word: [15:7]=len, [6:4]=prio, [3:0]=dest, upper bits 0 when DATA_WIDTH>16.
- DATA: len cycles with wr_vld=1. Word k (0..len-1) = k, zero-extended.
- EOP: wr_eop[i]=1, wr_vld=0. pkt_sent[i] increments, saturating at all-ones. done[i] is set when pkt_target≠0 and the new count equals pkt_target.
- GAP: GAP_CYC cycles with all outputs 0.
- Packet timeline: sop at cycle t, header at t+1, data t+2..t+len+1, eop at t+len+2. Per-packet period is len+4+GAP_CYC cycles (one IDLE cycle included).
- pause and enable are checked only in IDLE. Deasserting either mid-packet lets the packet complete.
- Length computation:
  - Fixed: cfg_len, with 0 forced to 1.
  - Incrementing: takes the current reg value, then reg = reg==MAX_LEN ? MIN_LEN : reg+1.
  - LFSR: 16-bit Fibonacci LFSR, taps 16,14,13,11, stepped once per SOP. Uses the low LEN_WIDTH bits, clamped to [MIN_LEN, MAX_LEN].
- Destination computation:
  - Fixed: cfg_dest.
  - Round-robin: uses the reg value, then reg = (reg+1) mod PORT_NUM.
  - LFSR: lfsr[3:0] mod PORT_NUM, using the same LFSR step as length.
- done clears only on reset. Lowering pkt_target below pkt_sent does not raise done; it sets only on equality.
- Channels are fully independent; simultaneous starts on all channels are legal.

Test Plan:
1. Fixed mode, cfg_len=31, cfg_prio=2, cfg_dest=5, enable=16'h0001, pkt_target=1, GAP_CYC=2 -> ch0 sop at t, header 16'h0FA5 at t+1, data 0..30 over 31 cycles, eop at t+33, pkt_sent[0]=1, done[0]=1, no further sop; other channels silent.
2. enable=16'hFFFF, dest_mode=1, pkt_target=4 -> channel i sends dests i,i+1,i+2,i+3 mod 16; all 16 done bits set; each pkt_sent=4.
3. len_mode=1, MIN_LEN=32, MAX_LEN=34, pkt_target=5 -> ch0 lengths 32,33,34,32,33 in the headers; vld-high count per packet = len+1.
4. pause[0] held high in IDLE for 10 cycles -> no sop; sop on the cycle after pause drops. pause raised during DATA -> packet completes with eop.
5. len_mode=2 -> every header length lies in [32,100]; two channels produce different sequences; the sequence repeats identically after a reset.
6. rst_n=0 for one cycle mid-DATA on ch3 -> next cycle all outputs 0, no eop, pkt_sent[3]=0; generation restarts from the SOP state.
